// File: rtl/count_display_driver_pkg.sv
// Shared constants and helpers for the count display driver: active-low
// 7-segment patterns ({g,f,e,d,c,b,a}) and the binary-to-two-digit split.
package count_disp_pkg;

  localparam int MAX_COUNT_DEF = 13;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Inputs never exceed 15, so a single conditional subtract of 10 suffices.
  function automatic bcd2_t bin_to_bcd2(input logic [3:0] v);
    bcd2_t r;
    r.tens = (v >= 4'd10) ? 4'd1 : 4'd0;
    r.ones = (v >= 4'd10) ? (v - 4'd10) : v;
    return r;
  endfunction

endpackage

// File: rtl/count_display_driver_seg7_encoder.sv
// Combinational decimal digit to active-low 7-segment pattern.
// Non-decimal codes show a dash so a bad digit is visible rather than silent.
module seg7_encoder
  import count_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Glitch-filters a mod-(MAX_COUNT+1) counter value, checks its stepping, and
// scans it as two decimal digits onto a multiplexed active-low 7-segment display.
module count_display_driver
  import count_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap_pulse,
  output logic       step_err
);

  localparam int             PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0]     MAXC    = 4'(MAX_COUNT);

  logic [3:0]    sample_q, sample_d;
  logic [3:0]    stable_q, stable_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic          digit_sel_q, digit_sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic          accept, is_inc, is_wrap, ps_last, blank;
  logic [3:0]    digit;
  bcd2_t         bcd;

  always_comb begin
    sample_d = count;
    // Two matching samples, in range, and actually different from what is shown.
    accept   = (count == sample_q) && (count <= MAXC) && (count != stable_q);
    is_inc   = ({1'b0, count} == ({1'b0, stable_q} + 5'd1));
    is_wrap  = (stable_q == MAXC) && (count == 4'd0);
    stable_d = accept ? count : stable_q;
    wrap_d   = accept && is_wrap;
    err_d    = err_q || (accept && !is_inc && !is_wrap);

    ps_last     = (prescaler_q == PS_LAST);
    prescaler_d = ps_last ? '0 : prescaler_q + PW'(1);
    digit_sel_d = digit_sel_q ^ ps_last;

    bcd   = bin_to_bcd2(stable_q);
    digit = digit_sel_q ? bcd.tens : bcd.ones;
    blank = BLANK_LZ && digit_sel_q && (bcd.tens == 4'd0);
    an_d  = digit_sel_q ? 2'b01 : 2'b10;
  end

  seg7_encoder u_enc (
    .digit (digit),
    .blank (blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_q    <= '0;
      stable_q    <= '0;
      prescaler_q <= '0;
      digit_sel_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 2'b11;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      stable_q    <= stable_d;
      prescaler_q <= prescaler_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign wrap_pulse = wrap_q;
  assign step_err   = err_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: directed scenarios plus random
// counter traffic, checked against a cycle-level behavioural model.
module tb_count_display_driver;

  localparam int SD = 4;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap_pulse;
  logic       step_err;

  count_display_driver #(.SCAN_DIV(SD), .MAX_COUNT(13), .BLANK_LZ(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .seg        (seg),
    .an         (an),
    .wrap_pulse (wrap_pulse),
    .step_err   (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [6:0] hi_tab [10];

  // Model state: edges since reset, last sampled value, displayed value, sticky error.
  int m_n, m_prev, m_v;
  bit m_err;

  task automatic step(input bit r, input int c);
    exp_t e;
    int   tens, ones;
    bit   acc, wrp;
    reset = r;
    count = 4'(c);
    e.wrap = 1'b0;
    e.err  = 1'b0;
    if (!r) begin
      e.seg = 7'h7F; e.an = 2'b11;
      m_n = 0; m_prev = 0; m_v = 0; m_err = 0;
    end else begin
      tens = m_v / 10;
      ones = m_v % 10;
      if (((m_n / SD) % 2) == 1) begin
        e.an  = 2'b01;
        e.seg = (tens == 0) ? 7'h7F : ~hi_tab[tens];
      end else begin
        e.an  = 2'b10;
        e.seg = ~hi_tab[ones];
      end
      acc = (c == m_prev) && (c <= 13) && (c != m_v);
      wrp = acc && (m_v == 13) && (c == 0);
      if (acc && !wrp && (c != m_v + 1)) m_err = 1'b1;
      e.wrap = wrp;
      e.err  = m_err;
      if (acc) m_v = c;
      m_prev = c;
      m_n++;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input int c, input int n);
    for (int i = 0; i < n; i++) step(1'b1, c);
  endtask

  // Monitor: one registered output set per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (seg !== e.seg || an !== e.an || wrap_pulse !== e.wrap || step_err !== e.err) begin
          errors++;
          $display("FAIL outputs cyc=%0d seg=%h exp=%h an=%b exp=%b wrap=%b exp=%b err=%b exp=%b",
                   cyc, seg, e.seg, an, e.an, wrap_pulse, e.wrap, step_err, e.err);
        end
      end
    end
  end

  initial begin
    int kind, nxt;
    hi_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reset with count present, then a steady 5 across both dwells.
    for (int i = 0; i < 3; i++) step(1'b0, 5);
    hold(5, 12);

    // Full legal count 0..13 -> 0, three cycles per value.
    step(1'b0, 0);
    for (int v = 0; v <= 13; v++) hold(v, 3);
    hold(0, 10);

    // Transient 14 before the wrap must be filtered.
    for (int v = 1; v <= 13; v++) hold(v, 3);
    hold(14, 1);
    hold(0, 6);

    // Long out-of-range value from a stable 4.
    for (int v = 1; v <= 4; v++) hold(v, 3);
    hold(15, 10);
    hold(4, 4);

    // Illegal jump 3 -> 7, then legal counting must keep the error.
    step(1'b0, 0);
    for (int v = 1; v <= 3; v++) hold(v, 3);
    hold(7, 3);
    for (int v = 8; v <= 12; v++) hold(v, 3);

    // Reset in the tens dwell with the prescaler at 2.
    step(1'b0, 11);
    hold(11, 2);
    hold(12, 4);
    step(1'b0, 0);
    hold(0, 12);

    // Random traffic: mostly legal steps, with glitches, jumps and resets.
    for (int it = 0; it < 400; it++) begin
      kind = int'($urandom_range(0, 9));
      nxt  = (m_v == 13) ? 0 : m_v + 1;
      case (kind)
        0, 1, 2, 3, 4, 5: hold(nxt, int'($urandom_range(1, 4)));
        6:                hold(int'($urandom_range(14, 15)), int'($urandom_range(1, 3)));
        7:                hold(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
        8:                for (int k = 0; k < int'($urandom_range(1, 2)); k++) step(1'b0, int'($urandom_range(0, 15)));
        default:          hold(nxt, 2);
      endcase
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
